// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue: multi-channel retire-to-Difftest commit buffer.
// Up to COMMIT_W retired instructions enter per cycle (channel 0 oldest),
// are compacted into an in-order circular FIFO, and drain one per cycle to
// the Difftest sink. Cycle/instruction counters and the trap event
// (opcode 7'h6b) are tracked alongside the queue.
//
// Handshakes:
//   input side  - a group is accepted on a clock edge when in_ready=1 and any
//                 in_valid bit is set; in_ready depends on registered state
//                 only, so a same-cycle pop never raises it.
//   output side - the head record transfers on a clock edge when
//                 out_valid=1 and out_ready=1; out_* are stable while
//                 out_valid=1 and out_ready=0.
//
// DEPTH must be a power of two, at least 2 and at least COMMIT_W.
module difftest_commit_queue #(
  parameter int COMMIT_W = 2,
  parameter int DEPTH    = 8,
  parameter int XLEN     = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COMMIT_W-1:0]      in_valid,
  input  logic [COMMIT_W*XLEN-1:0] in_pc,
  input  logic [COMMIT_W*32-1:0]   in_inst,
  input  logic [COMMIT_W-1:0]      in_wen,
  input  logic [COMMIT_W*5-1:0]    in_wdest,
  input  logic [COMMIT_W*XLEN-1:0] in_wdata,
  input  logic [XLEN-1:0]          in_a0,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_wen,
  output logic [7:0]               out_wdest,
  output logic [XLEN-1:0]          out_wdata,
  output logic                     trap_valid,
  output logic [7:0]               trap_code,
  output logic [XLEN-1:0]          trap_pc,
  output logic [63:0]              cycle_cnt,
  output logic [63:0]              instr_cnt,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] COMMIT_W_C = CW'(COMMIT_W);
  localparam logic [6:0]    TRAP_OP    = 7'h6b;

  // One queued commit record; trap tags the entry that ends the program.
  typedef struct packed {
    logic            trap;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            wen;
    logic [4:0]      wdest;
    logic [XLEN-1:0] wdata;
  } rec_t;

  rec_t            mem_q [DEPTH];
  rec_t            mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            trap_pending_q, trap_pending_d;
  logic            trap_valid_q, trap_valid_d;
  logic [7:0]      trap_code_q, trap_code_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [63:0]     cycle_cnt_q, cycle_cnt_d;
  logic [63:0]     instr_cnt_q, instr_cnt_d;
  logic            overflow_q, overflow_d;

  logic [COMMIT_W-1:0] trap_hit;
  logic [COMMIT_W-1:0] keep;
  logic                older_trap;
  logic                grp_trap;
  logic [XLEN-1:0]     grp_trap_pc;
  logic [CW-1:0]       free_slots;
  logic                any_valid;
  logic                push_fire;
  logic                pop_fire;
  logic [CW-1:0]       n_push;
  logic [PW-1:0]       slot;
  logic [PW-1:0]       widx;
  rec_t                new_rec;
  rec_t                head;

  // Only the trap code byte of x10 is recorded.
  logic unused_a0_hi;
  assign unused_a0_hi = ^in_a0[XLEN-1:8];

  // Per-channel trap detection; channels younger than the first trap are cut.
  always_comb begin
    trap_hit    = '0;
    keep        = '0;
    older_trap  = 1'b0;
    grp_trap    = 1'b0;
    grp_trap_pc = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      trap_hit[i] = in_valid[i] && (in_inst[i*32 +: 7] == TRAP_OP);
      keep[i]     = in_valid[i] && !older_trap;
      if (trap_hit[i] && !older_trap) begin
        grp_trap    = 1'b1;
        grp_trap_pc = in_pc[i*XLEN +: XLEN];
      end
      older_trap = older_trap | trap_hit[i];
    end
  end

  // Handshake qualifiers, all from registered occupancy and trap state.
  always_comb begin
    free_slots = DEPTH_C - count_q;
    any_valid  = |in_valid;
    in_ready   = (free_slots >= COMMIT_W_C) && !trap_pending_q && !trap_valid_q;
    out_valid  = (count_q != '0);
    push_fire  = in_ready && any_valid;
    pop_fire   = out_valid && out_ready;
  end

  // Compacting write of accepted channels into consecutive slots from wr_ptr.
  always_comb begin
    mem_d   = mem_q;
    n_push  = '0;
    slot    = '0;
    widx    = '0;
    new_rec = '0;
    if (push_fire) begin
      for (int i = 0; i < COMMIT_W; i++) begin
        if (keep[i]) begin
          new_rec.trap  = trap_hit[i];
          new_rec.pc    = in_pc[i*XLEN +: XLEN];
          new_rec.inst  = in_inst[i*32 +: 32];
          new_rec.wen   = in_wen[i];
          new_rec.wdest = in_wdest[i*5 +: 5];
          new_rec.wdata = in_wdata[i*XLEN +: XLEN];
          widx          = wr_ptr_q + slot;
          mem_d[widx]   = new_rec;
          slot          = slot + PW'(1);
          n_push        = n_push + CW'(1);
        end
      end
    end
  end

  // Pointer, occupancy, trap and counter next-state.
  always_comb begin
    wr_ptr_d       = wr_ptr_q + n_push[PW-1:0];
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q + n_push - CW'(pop_fire);
    trap_pending_d = trap_pending_q;
    trap_valid_d   = trap_valid_q;
    trap_code_d    = trap_code_q;
    trap_pc_d      = trap_pc_q;
    instr_cnt_d    = instr_cnt_q;
    overflow_d     = overflow_q;
    cycle_cnt_d    = trap_valid_q ? cycle_cnt_q : cycle_cnt_q + 64'd1;

    if (push_fire && grp_trap) begin
      trap_pending_d = 1'b1;
      trap_code_d    = in_a0[7:0];
      trap_pc_d      = grp_trap_pc;
    end

    // Input held off by a pending trap is expected, not an overflow.
    if (any_valid && !in_ready && !trap_pending_q) begin
      overflow_d = 1'b1;
    end

    if (pop_fire) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      instr_cnt_d = instr_cnt_q + 64'd1;
      if (head.trap) begin
        trap_valid_d   = 1'b1;
        trap_pending_d = 1'b0;
      end
    end
  end

  // Control state registers; reset wins over push, pop and trap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      trap_pending_q <= 1'b0;
      trap_valid_q   <= 1'b0;
      trap_code_q    <= '0;
      trap_pc_q      <= '0;
      cycle_cnt_q    <= '0;
      instr_cnt_q    <= '0;
      overflow_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      trap_pending_q <= trap_pending_d;
      trap_valid_q   <= trap_valid_d;
      trap_code_q    <= trap_code_d;
      trap_pc_q      <= trap_pc_d;
      cycle_cnt_q    <= cycle_cnt_d;
      instr_cnt_q    <= instr_cnt_d;
      overflow_q     <= overflow_d;
    end
  end

  // Record storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Head record and status outputs.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    out_pc       = head.pc;
    out_inst     = head.inst;
    out_wen      = head.wen;
    out_wdest    = {3'd0, head.wdest};
    out_wdata    = head.wdata;
    trap_valid   = trap_valid_q;
    trap_code    = trap_valid_q ? trap_code_q : 8'd0;
    trap_pc      = trap_valid_q ? trap_pc_q : '0;
    cycle_cnt    = cycle_cnt_q;
    instr_cnt    = instr_cnt_q;
    overflow_err = overflow_q;
  end

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Self-checking bench for difftest_commit_queue: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference model.
module tb_difftest_commit_queue;

  localparam int W  = 2;
  localparam int D  = 8;
  localparam int XL = 64;

  // ---------------- clock / reset / DUT ----------------
  logic            clock = 1'b0;
  logic            reset;
  logic [W-1:0]    in_valid;
  logic [W*XL-1:0] in_pc;
  logic [W*32-1:0] in_inst;
  logic [W-1:0]    in_wen;
  logic [W*5-1:0]  in_wdest;
  logic [W*XL-1:0] in_wdata;
  logic [XL-1:0]   in_a0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [XL-1:0]   out_pc;
  logic [31:0]     out_inst;
  logic            out_wen;
  logic [7:0]      out_wdest;
  logic [XL-1:0]   out_wdata;
  logic            trap_valid;
  logic [7:0]      trap_code;
  logic [XL-1:0]   trap_pc;
  logic [63:0]     cycle_cnt;
  logic [63:0]     instr_cnt;
  logic            overflow_err;

  always #5 clock = ~clock;

  difftest_commit_queue #(.COMMIT_W(W), .DEPTH(D), .XLEN(XL)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen),
    .in_wdest(in_wdest), .in_wdata(in_wdata), .in_a0(in_a0),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_wen(out_wen),
    .out_wdest(out_wdest), .out_wdata(out_wdata),
    .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .overflow_err(overflow_err)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
    bit          trap;
  } rec_t;

  rec_t        exp_q[$];
  bit          m_pending, m_trapped, m_ovf;
  logic [7:0]  m_code;
  logic [63:0] m_tpc, m_cyc, m_icnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_in_ready();
    return (D - exp_q.size() >= W) && !m_pending && !m_trapped;
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_pc", out_pc, exp_q[0].pc);
      chk("out_inst", out_inst, exp_q[0].inst);
      chk("out_wen", out_wen, exp_q[0].wen);
      chk("out_wdest", out_wdest, {3'd0, exp_q[0].wdest});
      chk("out_wdata", out_wdata, exp_q[0].wdata);
    end
    chk("in_ready", in_ready, model_in_ready());
    chk("trap_valid", trap_valid, m_trapped);
    chk("trap_code", trap_code, m_trapped ? m_code : 8'd0);
    chk("trap_pc", trap_pc, m_trapped ? m_tpc : 64'd0);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instr_cnt", instr_cnt, m_icnt);
    chk("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic model_update();
    rec_t r;
    bit   rdy, was_trapped, was_pending;
    if (!reset) begin
      exp_q.delete();
      m_pending = 0; m_trapped = 0; m_ovf = 0;
      m_code = 0; m_tpc = 0; m_cyc = 0; m_icnt = 0;
      return;
    end
    rdy         = model_in_ready();
    was_trapped = m_trapped;
    was_pending = m_pending;
    if (exp_q.size() != 0 && out_ready) begin
      r = exp_q.pop_front();
      m_icnt++;
      if (r.trap) begin
        m_trapped = 1;
        m_pending = 0;
      end
    end
    if (rdy && (in_valid != 0)) begin
      for (int ch = 0; ch < W; ch++) begin
        if (in_valid[ch]) begin
          r.pc    = in_pc[ch*XL +: XL];
          r.inst  = in_inst[ch*32 +: 32];
          r.wen   = in_wen[ch];
          r.wdest = in_wdest[ch*5 +: 5];
          r.wdata = in_wdata[ch*XL +: XL];
          r.trap  = (r.inst[6:0] == 7'h6b);
          exp_q.push_back(r);
          if (r.trap) begin
            m_pending = 1;
            m_code    = in_a0[7:0];
            m_tpc     = r.pc;
            break;
          end
        end
      end
    end else if ((in_valid != 0) && !was_pending) begin
      m_ovf = 1;
    end
    if (!was_trapped) m_cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic set_ch(input int ch, input logic [63:0] pc, input logic [31:0] inst);
    logic [31:0] r;
    r = $urandom();
    in_pc[ch*XL +: XL]    = pc;
    in_inst[ch*32 +: 32]  = inst;
    in_wen[ch]            = r[0];
    in_wdest[ch*5 +: 5]   = r[5:1];
    in_wdata[ch*XL +: XL] = {$urandom(), $urandom()};
  endtask

  task automatic rand_ch(input int ch);
    logic [31:0] r;
    logic [6:0]  op;
    r  = $urandom();
    op = ($urandom_range(0, 39) == 0) ? 7'h6b : 7'h13;
    set_ch(ch, {32'h0, $urandom()}, {r[31:7], op});
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = '0;
    tick();
    reset    = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; in_valid = '0; in_pc = '0; in_inst = '0; in_wen = '0;
    in_wdest = '0; in_wdata = '0; in_a0 = '0; out_ready = 1'b0;
    @(negedge clock);
    @(posedge clock);
    model_update();
    @(negedge clock);

    // Reset held low for two cycles.
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_cycle_cnt", cycle_cnt, 64'd0);
    reset = 1'b1;

    // Group push then drain.
    set_ch(0, 64'h8000_0000, 32'h0000_0013);
    set_ch(1, 64'h8000_0004, 32'h0010_0093);
    in_valid = 2'b11;
    tick();
    in_valid = '0;
    chk("grp_head_pc", out_pc, 64'h8000_0000);
    tick();
    out_ready = 1'b1;
    tick();
    chk("grp_second_pc", out_pc, 64'h8000_0004);
    tick();
    chk("grp_instr_cnt", instr_cnt, 64'd2);
    chk("grp_empty", out_valid, 1'b0);
    out_ready = 1'b0;

    // Gapped group: only channel 1 valid.
    set_ch(1, 64'h100, 32'h0000_0013);
    in_valid = 2'b10;
    tick();
    in_valid = '0;
    chk("gap_pc", out_pc, 64'h100);
    out_ready = 1'b1;
    tick();
    chk("gap_single", out_valid, 1'b0);
    out_ready = 1'b0;

    // Fill to DEPTH, overflow, drain across pointer wrap.
    for (int g = 0; g < D / W; g++) begin
      set_ch(0, 64'h200 + 64'(8 * g), 32'h0000_0013);
      set_ch(1, 64'h204 + 64'(8 * g), 32'h0000_0013);
      in_valid = 2'b11;
      tick();
    end
    chk("fill_in_ready", in_ready, 1'b0);
    chk("fill_no_ovf", overflow_err, 1'b0);
    set_ch(0, 64'hdead, 32'h0000_0013);
    tick();
    in_valid = '0;
    chk("fill_ovf", overflow_err, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < D; k++) begin
      chk("fill_drain_pc", out_pc, 64'h200 + 64'(4 * k));
      tick();
    end
    chk("fill_drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Trap on channel 0; channel 1 discarded.
    do_reset();
    in_a0 = 64'h5;
    set_ch(0, 64'h8000_0010, 32'h0000_006b);
    set_ch(1, 64'h8000_0014, 32'h0000_0013);
    in_valid = 2'b11;
    tick();
    chk("trap_blocks_ready", in_ready, 1'b0);
    chk("trap_not_yet", trap_valid, 1'b0);
    tick();
    chk("trap_pending_no_ovf", overflow_err, 1'b0);
    in_valid  = '0;
    out_ready = 1'b1;
    tick();
    chk("trap_valid", trap_valid, 1'b1);
    chk("trap_code_val", trap_code, 8'h05);
    chk("trap_pc_val", trap_pc, 64'h8000_0010);
    chk("trap_ch1_gone", out_valid, 1'b0);
    for (int k = 0; k < 3; k++) tick();

    // Reset in the middle of traffic.
    do_reset();
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      rand_ch(0); rand_ch(1);
      set_ch(0, 64'h300 + 64'(g), 32'h0000_0013);
      set_ch(1, 64'h380 + 64'(g), 32'h0000_0013);
      in_valid = (g == 2) ? 2'b01 : 2'b11;
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 2'b11;
    reset     = 1'b0;
    tick();
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    chk("midrst_empty", out_valid, 1'b0);
    chk("midrst_instr_cnt", instr_cnt, 64'd0);
    chk("midrst_ovf", overflow_err, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);

    // Randomized traffic with occasional resets (always after a trap).
    for (int c = 0; c < 1500; c++) begin
      rand_ch(0);
      rand_ch(1);
      in_a0     = {$urandom(), $urandom()};
      in_valid  = W'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 99) < ((c / 250) % 2 == 0 ? 75 : 30));
      if (m_trapped && $urandom_range(0, 5) == 0) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0)      reset = 1'b0;
      else                                        reset = 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/difftest_commit_queue.md
Name: difftest_commit_queue

Overview:
- Multi-channel commit buffer between a pipelined core's retire stage and the Difftest commit/trap ports.
- Accepts up to COMMIT_W retired instructions per cycle and queues them in program order in a DEPTH-entry FIFO.
- Drains one record per cycle to the Difftest sink with a valid/ready handshake.
- Maintains cycle and instruction counters, and latches the trap event (opcode 7'h6b) once the trapping instruction drains.

Parameters:
- COMMIT_W, 2, number of commit channels per cycle; 1..4.
- DEPTH, 8, FIFO entries; power of 2, must be >= COMMIT_W.
- XLEN, 64, data/PC width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  COMMIT_W  per-channel commit valid; channel 0 is oldest.
- in_pc  in  COMMIT_W*XLEN  packed PCs; channel i occupies [i*XLEN +: XLEN].
- in_inst  in  COMMIT_W*32  packed instructions.
- in_wen  in  COMMIT_W  per-channel register-write enable.
- in_wdest  in  COMMIT_W*5  packed destination register indices.
- in_wdata  in  COMMIT_W*XLEN  packed write data.
- in_a0  in  XLEN  current x10 value, sampled for the trap code.
- in_ready  out  1  queue can accept a full group.
- out_valid  out  1  head record valid.
- out_ready  in  1  sink accepts head.
- out_pc  out  XLEN  head PC.
- out_inst  out  32  head instruction.
- out_wen  out  1  head write enable.
- out_wdest  out  8  {3'd0, wdest}.
- out_wdata  out  XLEN  head write data.
- trap_valid  out  1  sticky trap flag.
- trap_code  out  8  in_a0[7:0] captured at trap push.
- trap_pc  out  XLEN  PC of the trapping instruction.
- cycle_cnt  out  64  cycles since reset, frozen once trapped.
- instr_cnt  out  64  records drained.
- overflow_err  out  1  sticky; set when a push arrives while in_ready=0.

Behaviour:
- Reset (reset=0 at a rising edge):
  - Pointers, count, counters, trap_valid, trap_code, trap_pc and overflow_err all go to 0.
  - Stored entries are don't-care.
  - Outputs: out_valid=0, in_ready=1.
- Storage:
  - Circular FIFO with wr_ptr, rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- in_ready = (DEPTH - count >= COMMIT_W) && !trap_pending && !trap_valid. It is combinational and uses the registered count only.
- Push (group accepted):
  - Occurs when in_ready=1 and any in_valid bit is set.
  - Valid channels are compacted in ascending channel index. Gaps are allowed; e.g. valid=2'b10 writes only channel 1, into slot wr_ptr.
  - wr_ptr and count advance by popcount(in_valid).
- Push while in_ready=0 with any valid bit set: the data is dropped, overflow_err is set, and queue state is unchanged.
- Pop:
  - Occurs when out_valid && out_ready; rd_ptr+1, count-1.
  - out_valid = (count != 0). out_* show the rd_ptr entry combinationally from storage, giving 1-cycle latency from push to out_valid.
- Simultaneous push and pop in the same cycle: count_next = count + pushed - popped.
- Full FIFO: a pop in a cycle does not raise in_ready in that same cycle. in_ready re-evaluates the next cycle.
- Trap:
  - Trigger: an accepted channel whose in_inst[6:0]==7'h6b.
  - On that cycle:
    - trap_code_r <= in_a0[7:0].
    - trap_pc_r <= that channel's PC.
    - trap_pending <= 1.
    - Only channels up to and including the trapping channel are pushed; younger valid channels in the group are discarded.
  - If several channels trap, the lowest index wins.
  - While pending: in_ready=0; overflow_err is not set for dropped input.
  - When the trap entry pops (each entry carries a trap tag bit): trap_valid <= 1, trap_pending <= 0.
  - trap_valid stays 1 until reset.
  - trap_code and trap_pc outputs are 0 until trap_valid is set.
- Counters:
  - cycle_cnt increments every cycle out of reset while trap_valid=0.
  - instr_cnt increments on each pop, including the trap entry.
  - Both wrap at 2^64 with no saturation.
- Reset mid-operation: reset overrides push, pop and trap in the same edge. The queue is empty the next cycle.

Test Plan:
- Reset with reset=0 for 2 cycles: out_valid=0, in_ready=1, cycle_cnt=0, instr_cnt=0, trap_valid=0, overflow_err=0.
- Group push and drain, COMMIT_W=2, out_ready=0:
  - Stimulus: push {pc 0x80000000 addi, pc 0x80000004 addi}.
  - Next cycle: out_valid=1, out_pc=0x80000000.
  - Raise out_ready: 0x80000000 then 0x80000004 drain on consecutive cycles; instr_cnt=2; out_valid=0 after.
- Gapped group: in_valid=2'b10 with pc 0x100 -> only one entry; out_pc=0x100; count=1.
- Fill to 8 entries with out_ready=0:
  - in_ready=0 once count>=7.
  - A further push sets overflow_err=1; entries remain 8.
  - Draining 8 returns PCs in push order across the pointer wrap.
- Trap on channel 0 with in_a0=0x5, pc=0x80000010:
  - Channel 1 entry is discarded; in_ready=0 thereafter.
  - trap_valid=1 only after the trap entry pops; trap_code=0x05, trap_pc=0x80000010.
  - cycle_cnt is frozen from the cycle after the pop.
- Mid-operation reset: reset=0 while count=5 with out_ready=1 -> next cycle count=0, out_valid=0, instr_cnt=0, overflow_err=0.
